mem_sweep_ctrl: RTL and testbench

//  Sequencer for one simple-dual-port block RAM (registered read, 1-cycle latency).
//  On a start pulse it sweeps every address once to fill the RAM with a constant,

---
 rtl/mem_sweep_ctrl_if.sv | 46 ++++
 rtl/mem_sweep_ctrl.sv | 120 ++++++++++++
 tb/tb_mem_sweep_ctrl.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_sweep_ctrl_if.sv
// User-port, RAM-port and status bundle for the block-RAM sweep sequencer.
// master = the sequencer itself; slave = the user logic and RAM around it.
interface mem_sweep_ctrl_if #(
  parameter int WID_MEM = 18,
  parameter int AW      = 12
);
  logic               start;
  logic [1:0]         mode;
  logic [WID_MEM-1:0] fill_val;

  logic [AW-1:0]      usr_raddr;
  logic [AW-1:0]      usr_waddr;
  logic [WID_MEM-1:0] usr_din;
  logic               usr_we;
  logic [WID_MEM-1:0] usr_dout;

  logic [AW-1:0]      mem_raddr;
  logic [AW-1:0]      mem_waddr;
  logic [WID_MEM-1:0] mem_din;
  logic               mem_we;
  logic [WID_MEM-1:0] mem_dout;

  logic               busy;
  logic               done;
  logic [31:0]        checksum;
  logic [AW:0]        err_cnt;
  logic [AW-1:0]      first_err_addr;

  modport master (
    input  start, mode, fill_val,
    input  usr_raddr, usr_waddr, usr_din, usr_we,
    output usr_dout,
    output mem_raddr, mem_waddr, mem_din, mem_we,
    input  mem_dout,
    output busy, done, checksum, err_cnt, first_err_addr
  );

  modport slave (
    output start, mode, fill_val,
    output usr_raddr, usr_waddr, usr_din, usr_we,
    input  usr_dout,
    input  mem_raddr, mem_waddr, mem_din, mem_we,
    output mem_dout,
    input  busy, done, checksum, err_cnt, first_err_addr
  );
endinterface

// File: rtl/mem_sweep_ctrl.sv
// Block-RAM sweep sequencer: fill, checksum or verify every address on a start pulse.
// Passes the user port through to the RAM while idle and owns the RAM while sweeping.
module mem_sweep_ctrl #(
  parameter int WID_MEM   = 18,
  parameter int DEPTH_MEM = 4096,
  parameter int AW        = 12
) (
  input  logic             clk,
  input  logic             reset_n,
  mem_sweep_ctrl_if.master bus
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH_MEM - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_DRAIN = 2'b10,
    S_DONE  = 2'b11
  } state_e;

  typedef enum logic [1:0] {
    OP_SUM    = 2'b00,
    OP_FILL   = 2'b01,
    OP_VERIFY = 2'b10,
    OP_RSVD   = 2'b11
  } op_e;

  state_e             state_q, state_d;
  op_e                op_q;
  logic [WID_MEM-1:0] fill_q;
  logic [AW-1:0]      cnt_q;
  logic [AW-1:0]      cnt_d_q;
  logic               rd_vld_q;
  logic [31:0]        checksum_q;
  logic [AW:0]        err_q;
  logic [AW-1:0]      first_q;
  logic               accept;

  assign accept = (state_q == S_IDLE) && bus.start && (bus.mode != OP_RSVD);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (accept) state_d = S_RUN;
      S_RUN:   if (cnt_q == LAST) state_d = S_DRAIN;
      S_DRAIN: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      op_q       <= OP_SUM;
      fill_q     <= '0;
      cnt_q      <= '0;
      cnt_d_q    <= '0;
      rd_vld_q   <= 1'b0;
      checksum_q <= '0;
      err_q      <= '0;
      first_q    <= '0;
    end else begin
      state_q  <= state_d;
      // Read data returns one cycle after the address; tag it with the delayed count.
      rd_vld_q <= (state_q == S_RUN) && (op_q != OP_FILL);
      cnt_d_q  <= cnt_q;

      if (accept) begin
        op_q       <= op_e'(bus.mode);
        fill_q     <= bus.fill_val;
        cnt_q      <= '0;
        checksum_q <= '0;
        err_q      <= '0;
        first_q    <= '0;
      end else if (state_q == S_RUN) begin
        cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + AW'(1);
      end

      if (rd_vld_q) begin
        if (op_q == OP_SUM) begin
          checksum_q <= checksum_q + 32'(bus.mem_dout);
        end else if ((op_q == OP_VERIFY) && (bus.mem_dout != fill_q)) begin
          err_q <= err_q + (AW+1)'(1);
          if (err_q == '0) first_q <= cnt_d_q;
        end
      end
    end
  end

  // User writes reach the RAM only in IDLE, so the two writers never collide.
  always_comb begin
    bus.mem_raddr = bus.usr_raddr;
    bus.mem_waddr = bus.usr_waddr;
    bus.mem_din   = bus.usr_din;
    bus.mem_we    = 1'b0;
    unique case (state_q)
      S_IDLE: bus.mem_we = bus.usr_we;
      S_RUN: begin
        if (op_q == OP_FILL) begin
          bus.mem_waddr = cnt_q;
          bus.mem_din   = fill_q;
          bus.mem_we    = 1'b1;
        end else begin
          bus.mem_raddr = cnt_q;
        end
      end
      default: ;
    endcase
  end

  assign bus.usr_dout       = bus.mem_dout;
  assign bus.busy           = (state_q != S_IDLE);
  assign bus.done           = (state_q == S_DONE);
  assign bus.checksum       = checksum_q;
  assign bus.err_cnt        = err_q;
  assign bus.first_err_addr = first_q;

endmodule

// File: tb/tb_mem_sweep_ctrl.sv
// Bench for mem_sweep_ctrl: RAM model, sweep-level reference model, per-cycle compare,
// and directed scenarios with hand-computed results.
module tb_mem_sweep_ctrl;

  localparam int W = 18;
  localparam int D = 4096;
  localparam int A = 12;

  logic clk;
  logic reset_n;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;

  mem_sweep_ctrl_if #(.WID_MEM(W), .AW(A)) bus ();

  mem_sweep_ctrl #(.WID_MEM(W), .DEPTH_MEM(D), .AW(A)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Simple-dual-port RAM with registered read.
  logic [W-1:0] ram [D];
  always @(posedge clk) begin
    if (bus.mem_we) ram[bus.mem_waddr] <= bus.mem_din;
    bus.mem_dout <= ram[bus.mem_raddr];
  end

  // Reference model: m_k counts cycles since the accepted start (0 = idle).
  int           m_k = 0;
  logic [1:0]   m_mode = 2'b00;
  logic [W-1:0] m_fill = '0;
  logic [31:0]  exp_sum = '0;
  int           exp_err = 0;
  int           exp_first = 0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_k = 0; exp_sum = '0; exp_err = 0; exp_first = 0;
    end else if (m_k == 0) begin
      if (bus.start && bus.mode != 2'b11) begin
        m_k = 1; m_mode = bus.mode; m_fill = bus.fill_val;
        exp_sum = '0; exp_err = 0; exp_first = 0;
      end
    end else if (m_k == D + 1) begin
      m_k = D + 2;
      for (int a = 0; a < D; a++) begin
        if (m_mode == 2'b00) exp_sum = exp_sum + 32'(ram[a]);
        if (m_mode == 2'b10 && ram[a] !== m_fill) begin
          if (exp_err == 0) exp_first = a;
          exp_err++;
        end
      end
    end else if (m_k == D + 2) begin
      m_k = 0;
    end else begin
      m_k++;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 30)
        $display("FAIL %s: got %0h, required %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic compare_loop;
    forever begin
      @(negedge clk);
      if (reset_n) begin
        chk("busy", 32'(bus.busy), 32'(m_k != 0));
        chk("done", 32'(bus.done), 32'(m_k == D + 2));
        chk("usr_dout", 32'(bus.usr_dout), 32'(bus.mem_dout));
        if (m_k == 0) begin
          chk("idle_we", 32'(bus.mem_we), 32'(bus.usr_we));
          chk("idle_waddr", 32'(bus.mem_waddr), 32'(bus.usr_waddr));
          chk("idle_din", 32'(bus.mem_din), 32'(bus.usr_din));
          chk("idle_raddr", 32'(bus.mem_raddr), 32'(bus.usr_raddr));
        end else if (m_k <= D) begin
          if (m_mode == 2'b01) begin
            chk("fill_we", 32'(bus.mem_we), 32'd1);
            chk("fill_waddr", 32'(bus.mem_waddr), 32'(m_k - 1));
            chk("fill_din", 32'(bus.mem_din), 32'(m_fill));
          end else begin
            chk("read_we", 32'(bus.mem_we), 32'd0);
            chk("read_raddr", 32'(bus.mem_raddr), 32'(m_k - 1));
          end
        end else begin
          chk("tail_we", 32'(bus.mem_we), 32'd0);
        end
        if (m_k == 0 || m_k == D + 2) begin
          chk("checksum", bus.checksum, exp_sum);
          chk("err_cnt", 32'(bus.err_cnt), 32'(exp_err));
          chk("first_err_addr", 32'(bus.first_err_addr), 32'(exp_first));
        end
      end
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [1:0] md, input logic [W-1:0] val, output int lat);
    int t0;
    t0 = cyc;
    bus.start = 1'b1; bus.mode = md; bus.fill_val = val;
    tick;
    bus.start = 1'b0;
    lat = -1;
    for (int i = 0; i < 5000; i++) begin
      if (bus.done) begin
        lat = cyc - t0;
        break;
      end
      tick;
    end
    tick;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, t0, ndone, at, bad;
    reset_n = 1'b0;
    bus.start = 1'b0; bus.mode = 2'b00; bus.fill_val = '0;
    bus.usr_raddr = 12'd3; bus.usr_waddr = '0; bus.usr_din = '0; bus.usr_we = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
    chk("rst_checksum", bus.checksum, 32'd0);
    chk("rst_err_cnt", 32'(bus.err_cnt), 32'd0);
    chk("rst_first", 32'(bus.first_err_addr), 32'd0);
    reset_n = 1'b1;
    fork compare_loop(); join_none
    tick;

    // 1: fill then verify with the same pattern
    run_op(2'b01, 18'h2AAAA, lat);  chk("t1_fill_lat", lat, 32'd4098);
    run_op(2'b10, 18'h2AAAA, lat);  chk("t1_ver_lat", lat, 32'd4098);
    chk("t1_err_cnt", 32'(bus.err_cnt), 32'd0);
    chk("t1_first", 32'(bus.first_err_addr), 32'd0);

    // 2: one user write corrupts address 5
    run_op(2'b01, 18'h0, lat);
    bus.usr_we = 1'b1; bus.usr_waddr = 12'd5; bus.usr_din = 18'h1;
    tick;
    bus.usr_we = 1'b0;
    run_op(2'b10, 18'h0, lat);
    chk("t2_err_cnt", 32'(bus.err_cnt), 32'd1);
    chk("t2_first", 32'(bus.first_err_addr), 32'd5);

    // 3: checksums of constant fills
    run_op(2'b01, 18'h00001, lat);
    run_op(2'b00, 18'h0, lat);      chk("t3_sum_lat", lat, 32'd4098);
    chk("t3_sum_ones", bus.checksum, 32'd4096);
    run_op(2'b01, 18'h3FFFF, lat);
    run_op(2'b00, 18'h0, lat);
    chk("t3_sum_max", bus.checksum, 32'h3FFFF000);

    // 4: second start and user writes during a fill are both ignored
    t0 = cyc;
    bus.start = 1'b1; bus.mode = 2'b01; bus.fill_val = 18'h12345;
    bus.usr_we = 1'b1; bus.usr_waddr = 12'd7; bus.usr_din = 18'h0;
    tick;
    ndone = 0; at = -1;
    for (int i = 0; i < 4130; i++) begin
      bus.start = (cyc == t0 + 10);
      bus.usr_waddr = bus.usr_waddr + 12'd1;
      if (bus.done) begin
        ndone++; at = cyc - t0; bus.usr_we = 1'b0;
      end
      tick;
    end
    bus.start = 1'b0; bus.usr_we = 1'b0;
    chk("t4_done_count", 32'(ndone), 32'd1);
    chk("t4_done_lat", at, 32'd4098);
    bad = 0;
    for (int a = 0; a < D; a++) if (ram[a] !== 18'h12345) bad++;
    chk("t4_ram_bad_words", 32'(bad), 32'd0);

    // 5: reset in RUN cycle 100 of a fill
    t0 = cyc;
    bus.start = 1'b1; bus.mode = 2'b01; bus.fill_val = 18'h00F0F;
    tick;
    bus.start = 1'b0;
    for (int i = 0; i < 200 && cyc < t0 + 101; i++) tick;
    #2 reset_n = 1'b0;
    #1;
    chk("t5_busy", 32'(bus.busy), 32'd0);
    chk("t5_done", 32'(bus.done), 32'd0);
    chk("t5_mem_we", 32'(bus.mem_we), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    tick;
    bad = 0;
    for (int a = 0; a < D; a++)
      if (ram[a] !== ((a < 100) ? 18'h00F0F : 18'h12345)) bad++;
    chk("t5_ram_bad_words", 32'(bad), 32'd0);
    chk("t5_checksum", bus.checksum, 32'd0);

    // 6: reserved mode ignored, then a normal verify of the partial fill
    bus.start = 1'b1; bus.mode = 2'b11; bus.fill_val = 18'h00F0F;
    tick;
    bus.start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      chk("t6_busy", 32'(bus.busy), 32'd0);
      chk("t6_done", 32'(bus.done), 32'd0);
      tick;
    end
    run_op(2'b10, 18'h00F0F, lat);  chk("t6_ver_lat", lat, 32'd4098);
    chk("t6_err_cnt", 32'(bus.err_cnt), 32'd3996);
    chk("t6_first", 32'(bus.first_err_addr), 32'd100);

    repeat (3) tick;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
